// File: rtl/uart_pkg.sv
// Shared types and helpers for the word-oriented UART transmitter (and a future receiver).
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Bits on the line per character: start + data + optional parity + stop.
    function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
        return 1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..PRESCALER-1 while running and flags the last count.
module uart_baud_gen #(
    parameter int PRESCALER = 200
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_run,
    output logic o_tick
);

    localparam int              CNT_W = $clog2(PRESCALER);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALER - 1);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count <= '0;
        end else if (!i_run || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign o_tick = i_run && (count == LAST);

endmodule

// File: rtl/uart_tx_word.sv
// UART transmitter that frames and serialises a multi-character word behind a valid/ready handshake.
module uart_tx_word
    import uart_pkg::*;
#(
    parameter int WORD_CHARS     = 4,
    parameter int DATA_BITS      = 8,
    parameter int PARITY         = 0,
    parameter int STOP_BITS      = 1,
    parameter int MSC_FIRST      = 1,
    parameter int BAUD_PRESCALER = 200
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic [WORD_CHARS*DATA_BITS-1:0] i_data,
    input  logic                            i_valid,
    output logic                            o_ready,
    output logic                            o_busy,
    output logic                            o_char_done,
    output logic                            o_tx
);

    localparam int                BIT_W     = $clog2(DATA_BITS);
    localparam int                CHAR_W    = (WORD_CHARS > 1) ? $clog2(WORD_CHARS) : 1;
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);
    localparam logic [CHAR_W-1:0] LAST_CHAR = CHAR_W'(WORD_CHARS - 1);
    localparam logic              STOP_LAST = (STOP_BITS == 2);

    if (WORD_CHARS < 1 || DATA_BITS < 5 || DATA_BITS > 8 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 || BAUD_PRESCALER < 2 ||
        frame_bits(DATA_BITS, PARITY, STOP_BITS) > 12) begin : g_bad_params
        $error("uart_tx_word: unsupported parameter combination");
    end

    state_t                          state, state_next;
    logic [WORD_CHARS*DATA_BITS-1:0] word;
    logic [BIT_W-1:0]                bit_idx, bit_idx_next;
    logic                            stop_idx, stop_idx_next;
    logic [CHAR_W-1:0]               char_idx, char_idx_next;
    logic [CHAR_W-1:0]               char_sel;
    logic [DATA_BITS-1:0]            cur_char;
    logic                            parity_bit;
    logic                            load;
    logic                            done_next;
    logic                            tx_next;
    logic                            run;
    logic                            tick;

    assign run = (state != ST_IDLE);

    uart_baud_gen #(
        .PRESCALER(BAUD_PRESCALER)
    ) u_baud (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_run (run),
        .o_tick(tick)
    );

    assign char_sel = (MSC_FIRST != 0) ? (LAST_CHAR - char_idx) : char_idx;

    always_comb begin
        cur_char = '0;
        for (int k = 0; k < WORD_CHARS; k++) begin
            if (char_sel == CHAR_W'(k)) begin
                cur_char = word[k*DATA_BITS +: DATA_BITS];
            end
        end
    end

    assign parity_bit = (PARITY == PARITY_ODD) ? ~^cur_char : ^cur_char;

    // NOTE: every always_comb output gets a default first, so no path through the block infers a latch.
    always_comb begin
        state_next    = state;
        bit_idx_next  = bit_idx;
        stop_idx_next = stop_idx;
        char_idx_next = char_idx;
        load          = 1'b0;
        done_next     = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (i_valid) begin
                    load          = 1'b1;
                    state_next    = ST_START;
                    bit_idx_next  = '0;
                    stop_idx_next = 1'b0;
                    char_idx_next = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_next   = ST_DATA;
                    bit_idx_next = '0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_idx == LAST_BIT) begin
                        bit_idx_next  = '0;
                        stop_idx_next = 1'b0;
                        state_next    = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_idx_next = bit_idx + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_next    = ST_STOP;
                    stop_idx_next = 1'b0;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (stop_idx == STOP_LAST) begin
                        stop_idx_next = 1'b0;
                        done_next     = 1'b1;
                        if (char_idx == LAST_CHAR) begin
                            state_next    = ST_IDLE;
                            char_idx_next = '0;
                        end else begin
                            state_next    = ST_START;
                            char_idx_next = char_idx + 1'b1;
                        end
                    end else begin
                        stop_idx_next = 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Line level is decided from the next state so o_tx can be a plain flop.
        case (state_next)
            ST_START:  tx_next = 1'b0;
            ST_DATA:   tx_next = cur_char[bit_idx_next];
            ST_PARITY: tx_next = parity_bit;
            default:   tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            bit_idx     <= '0;
            stop_idx    <= 1'b0;
            char_idx    <= '0;
            o_tx        <= 1'b1;
            o_ready     <= 1'b1;
            o_char_done <= 1'b0;
        end else begin
            state       <= state_next;
            bit_idx     <= bit_idx_next;
            stop_idx    <= stop_idx_next;
            char_idx    <= char_idx_next;
            o_tx        <= tx_next;
            o_ready     <= (state_next == ST_IDLE);
            o_char_done <= done_next;
        end
    end

    // NOTE: the word register is pure datapath, loaded before any use, so it carries no reset.
    always_ff @(posedge i_clk) begin
        if (load) begin
            word <= i_data;
        end
    end

    assign o_busy = ~o_ready;

endmodule

// File: tb/tb_uart_tx_word.sv
// Self-checking bench: four transmitter configurations against a timing-arithmetic line model.
module tb_uart_tx_word;

    typedef struct packed {
        int w;
        int db;
        int par;
        int stop;
        int msc;
        int p;
    } cfg_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  valid;
    logic [31:0] data [4];
    logic [3:0]  tx, rdy, bsy, dn;

    int          n_cmp  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    bit          act  [4] = '{default: 1'b0};
    int          nacc [4] = '{default: 0};
    logic [31:0] wrd  [4] = '{default: 32'h0};
    int          done_q [$];
    bit          churn = 1'b0;

    always #5 clk = ~clk;

    uart_tx_word #(.WORD_CHARS(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                   .MSC_FIRST(1), .BAUD_PRESCALER(4)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_data(data[0]), .i_valid(valid[0]),
        .o_ready(rdy[0]), .o_busy(bsy[0]), .o_char_done(dn[0]), .o_tx(tx[0]));

    uart_tx_word #(.WORD_CHARS(1), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2),
                   .MSC_FIRST(1), .BAUD_PRESCALER(4)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_data(data[1][6:0]), .i_valid(valid[1]),
        .o_ready(rdy[1]), .o_busy(bsy[1]), .o_char_done(dn[1]), .o_tx(tx[1]));

    uart_tx_word #(.WORD_CHARS(1), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2),
                   .MSC_FIRST(1), .BAUD_PRESCALER(2)) dut_c (
        .i_clk(clk), .i_rst(rst), .i_data(data[2][6:0]), .i_valid(valid[2]),
        .o_ready(rdy[2]), .o_busy(bsy[2]), .o_char_done(dn[2]), .o_tx(tx[2]));

    uart_tx_word #(.WORD_CHARS(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                   .MSC_FIRST(0), .BAUD_PRESCALER(2)) dut_d (
        .i_clk(clk), .i_rst(rst), .i_data(data[3]), .i_valid(valid[3]),
        .o_ready(rdy[3]), .o_busy(bsy[3]), .o_char_done(dn[3]), .o_tx(tx[3]));

    function automatic cfg_t cfg_of(input int i);
        cfg_t c;
        case (i)
            0:       c = '{w: 4, db: 8, par: 0, stop: 1, msc: 1, p: 4};
            1:       c = '{w: 1, db: 7, par: 2, stop: 2, msc: 1, p: 4};
            2:       c = '{w: 1, db: 7, par: 1, stop: 2, msc: 1, p: 2};
            default: c = '{w: 4, db: 8, par: 0, stop: 1, msc: 0, p: 2};
        endcase
        return c;
    endfunction

    function automatic int frame_len(input cfg_t c);
        return 1 + c.db + ((c.par != 0) ? 1 : 0) + c.stop;
    endfunction

    function automatic int word_len(input cfg_t c);
        return c.w * frame_len(c) * c.p;
    endfunction

    // Line level of frame position pos (0 = start bit) of the ch-th character sent.
    function automatic bit frame_bit(input cfg_t c, input logic [31:0] w, input int ch, input int pos);
        int          sel;
        int          ones;
        logic [31:0] chr;
        sel  = (c.msc != 0) ? (c.w - 1 - ch) : ch;
        chr  = (w >> (sel * c.db)) & ((32'd1 << c.db) - 32'd1);
        ones = $countones(chr);
        if (pos == 0) return 1'b0;
        if (pos <= c.db) return chr[pos-1];
        if (c.par != 0 && pos == c.db + 1) return (c.par == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
        return 1'b1;
    endfunction

    function automatic bit model_idle(input int i, input int t);
        return !act[i] || (t >= nacc[i] + word_len(cfg_of(i)));
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Model: accept decisions follow from the model's own idea of when each word ends.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                act[i] <= 1'b0;
            end else if (valid[i] && model_idle(i, cyc)) begin
                act[i]  <= 1'b1;
                nacc[i] <= cyc + 1;
                wrd[i]  <= data[i];
            end
        end
    end

    task automatic expect_out(input int i, output bit etx, output bit erd, output bit edn);
        cfg_t c;
        int   f, d, off, per;
        c   = cfg_of(i);
        f   = frame_len(c);
        d   = word_len(c);
        etx = 1'b1;
        erd = 1'b1;
        edn = 1'b0;
        if (!rst && act[i]) begin
            if (cyc >= nacc[i] && cyc < nacc[i] + d) begin
                off = cyc - nacc[i];
                per = off / c.p;
                erd = 1'b0;
                etx = frame_bit(c, wrd[i], per / f, per % f);
            end
            if (cyc > nacc[i] && cyc <= nacc[i] + d && ((cyc - nacc[i]) % (f * c.p)) == 0) begin
                edn = 1'b1;
            end
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            bit etx, erd, edn;
            expect_out(i, etx, erd, edn);
            check($sformatf("dut%0d outputs {tx,ready,busy,done} at cycle %0d", i, cyc),
                  64'({tx[i], rdy[i], bsy[i], dn[i]}), 64'({etx, erd, ~erd, edn}));
        end
    end

    always @(negedge clk) begin
        if (dn[0]) done_q.push_back(cyc);
    end

    task automatic send(input int i, input logic [31:0] w);
        @(posedge clk);
        #1;
        valid[i] = 1'b1;
        data[i]  = w;
        @(posedge clk);
        #1;
        valid[i] = 1'b0;
    endtask

    // Samples the first cycle of each bit period, starting with the start bit.
    task automatic capture(input int i, input int nb, input int p, output logic [63:0] bits);
        bits = '0;
        for (int k = 0; k < nb; k++) begin
            if (k > 0) repeat (p) @(posedge clk);
            @(negedge clk);
            bits[k] = tx[i];
        end
    endtask

    task automatic wait_ready(input int i, output int t);
        bit seen;
        seen = 1'b0;
        t    = -1;
        for (int n = 0; n < 5000 && !seen; n++) begin
            @(negedge clk);
            if (rdy[i]) begin
                seen = 1'b1;
                t    = cyc;
            end
        end
        if (!seen) check($sformatf("dut%0d ready within budget", i), 64'(rdy[i]), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] bits;
        int          t;

        rst   = 1'b1;
        valid = '0;
        for (int i = 0; i < 4; i++) data[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("dut%0d reset state", i), 64'({tx[i], rdy[i], bsy[i], dn[i]}), 64'(4'b1100));
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // 8N1 word, MSC first, prescaler 4.
        done_q.delete();
        send(0, 32'hA53C00FF);
        capture(0, 40, 4, bits);
        check("dutA line A5,3C,00,FF", 64'(bits[39:0]), 64'({10'h3FE, 10'h200, 10'h278, 10'h34A}));
        wait_ready(0, t);
        check("dutA accept-to-ready clocks", 64'(t - nacc[0]), 64'd160);
        @(negedge clk);
        check("dutA char_done count", 64'(done_q.size()), 64'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < done_q.size()) begin
                check($sformatf("dutA char_done %0d offset", k), 64'(done_q[k] - nacc[0]), 64'(40 * (k + 1)));
            end
        end

        // 7 data bits, even then odd parity, two stop bits.
        send(1, 32'h55);
        capture(1, 11, 4, bits);
        check("dutB 7E2 frame", 64'(bits[10:0]), 64'(11'h6AA));
        wait_ready(1, t);
        check("dutB accept-to-ready clocks", 64'(t - nacc[1]), 64'd44);

        send(2, 32'h55);
        capture(2, 11, 2, bits);
        check("dutC 7O2 frame", 64'(bits[10:0]), 64'(11'h7AA));
        wait_ready(2, t);
        check("dutC accept-to-ready clocks", 64'(t - nacc[2]), 64'd22);

        // Character 0 first, minimum prescaler.
        send(3, 32'h01020304);
        capture(3, 40, 2, bits);
        check("dutD line 04,03,02,01", 64'(bits[39:0]), 64'({10'h202, 10'h204, 10'h206, 10'h208}));
        wait_ready(3, t);
        check("dutD accept-to-ready clocks", 64'(t - nacc[3]), 64'd80);

        // Valid held high while data changes every cycle.
        @(posedge clk);
        #1;
        valid[0] = 1'b1;
        data[0]  = $urandom;
        churn    = 1'b1;
        fork
            begin
                while (churn) begin
                    @(posedge clk);
                    #1;
                    data[0] = $urandom;
                end
            end
        join_none
        @(posedge clk);
        #1;
        for (int w = 0; w < 3; w++) begin
            wait_ready(0, t);
            @(negedge clk);
            check($sformatf("b2b word %0d ready lasts one cycle", w), 64'(rdy[0]), 64'd0);
            check($sformatf("b2b word %0d next accept edge", w), 64'(nacc[0]), 64'(t + 1));
        end
        valid[0] = 1'b0;
        churn    = 1'b0;
        wait_ready(0, t);
        @(posedge clk);

        // Abort in the middle of the data bits of character 2.
        send(0, 32'h11000044);
        while (cyc < nacc[0] + 57) @(negedge clk);
        check("tx low before abort", 64'(tx[0]), 64'd0);
        #2;
        rst = 1'b1;
        #1;
        check("abort outputs immediate", 64'({tx[0], rdy[0], bsy[0], dn[0]}), 64'(4'b1100));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        send(0, 32'h12345678);
        capture(0, 40, 4, bits);
        check("post-abort line 12,34,56,78", 64'(bits[39:0]), 64'({10'h2F0, 10'h2AC, 10'h268, 10'h224}));
        wait_ready(0, t);
        check("post-abort accept-to-ready clocks", 64'(t - nacc[0]), 64'd160);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
